e_dec_digits: RTL and testbench

Downstream stage of the e-calculation datapath. Converts the multi-word fixed-point result of the squaring stage into a stream of BCD decimal digits: first the integer digit, then `NDIGITS` fractional digits. Fractional digits come from repeated multiply-by-10 on the fraction. The digit stream leaves over a valid/ready handshake toward the display/UART formatter.

---
 rtl/e_dec_digits.sv | 96 +++++++++
 tb/tb_e_dec_digits.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/e_dec_digits.sv
// Fixed-point to BCD digit streamer: emits the integer digit, then NDIGITS
// fractional digits obtained by repeated multiply-by-10 of the fraction.
module e_dec_digits #(
    parameter  int WORDS   = 32,
    parameter  int NDIGITS = 100,
    localparam int FW      = 16 * (WORDS - 1),
    localparam int CW      = $clog2(NDIGITS + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [16*WORDS-1:0]  in_data,
    output logic                 busy,
    output logic                 done,
    output logic                 int_ovf,
    output logic                 dig_valid,
    input  logic                 dig_ready,
    output logic [3:0]           dig_data,
    output logic [CW-1:0]        dig_index,
    output logic                 dig_last
);

    typedef enum logic [2:0] {
        IDLE,
        INT_OUT,
        CALC,
        FRAC_OUT,
        DONE
    } state_t;

    state_t        state;
    logic [FW-1:0] frac;
    logic [CW-1:0] cnt;
    logic [3:0]    dig_r;
    logic          ovf_r;

    logic [15:0]   int_part;
    logic [FW+3:0] prod;
    logic          at_last;

    assign int_part = in_data[16*WORDS-1 -: 16];
    // frac*10 as two shifts; the top nibble is the next decimal digit (0..9).
    assign prod     = ({4'b0, frac} << 3) + ({4'b0, frac} << 1);
    assign at_last  = (cnt == CW'(NDIGITS));

    // NOTE: sequential state uses non-blocking assignments so every register
    // in this block samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            frac  <= '0;
            cnt   <= '0;
            dig_r <= '0;
            ovf_r <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        frac <= in_data[FW-1:0];
                        cnt  <= '0;
                        if (int_part <= 16'd9) begin
                            dig_r <= int_part[3:0];
                            ovf_r <= 1'b0;
                        end else begin
                            dig_r <= 4'hF;
                            ovf_r <= 1'b1;
                        end
                        state <= INT_OUT;
                    end
                end
                INT_OUT: begin
                    if (dig_ready) state <= CALC;
                end
                CALC: begin
                    dig_r <= prod[FW+3:FW];
                    frac  <= prod[FW-1:0];
                    cnt   <= cnt + CW'(1);
                    state <= FRAC_OUT;
                end
                FRAC_OUT: begin
                    if (dig_ready) state <= at_last ? DONE : CALC;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign dig_valid = (state == INT_OUT) || (state == FRAC_OUT);
    assign busy      = (state == INT_OUT) || (state == CALC) || (state == FRAC_OUT);
    assign done      = (state == DONE);
    assign dig_data  = dig_r;
    assign dig_index = cnt;
    assign dig_last  = (state == FRAC_OUT) && at_last;
    assign int_ovf   = ovf_r;

endmodule

// File: tb/tb_e_dec_digits.sv
// Bench for e_dec_digits: a small instance (WORDS=2, NDIGITS=4) for directed and
// random streams, and a full-width instance fed a series-computed e.
module tb_e_dec_digits;

    localparam int S_W  = 2;
    localparam int S_N  = 4;
    localparam int S_FW = 16 * (S_W - 1);
    localparam int S_CW = $clog2(S_N + 1);
    localparam int B_W  = 32;
    localparam int B_N  = 100;
    localparam int B_FW = 16 * (B_W - 1);
    localparam int B_CW = $clog2(B_N + 1);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic dig_ready = 1'b0;

    logic                s_start = 1'b0;
    logic [16*S_W-1:0]   s_in = '0;
    logic                s_busy, s_done, s_ovf, s_valid, s_last;
    logic [3:0]          s_data;
    logic [S_CW-1:0]     s_index;

    logic                b_start = 1'b0;
    logic [16*B_W-1:0]   b_in = '0;
    logic                b_busy, b_done, b_ovf, b_valid, b_last;
    logic [3:0]          b_data;
    logic [B_CW-1:0]     b_index;

    e_dec_digits #(.WORDS(S_W), .NDIGITS(S_N)) u_small (
        .clk(clk), .rst_n(rst_n), .start(s_start), .in_data(s_in),
        .busy(s_busy), .done(s_done), .int_ovf(s_ovf), .dig_valid(s_valid),
        .dig_ready(dig_ready), .dig_data(s_data), .dig_index(s_index), .dig_last(s_last)
    );

    e_dec_digits #(.WORDS(B_W), .NDIGITS(B_N)) u_big (
        .clk(clk), .rst_n(rst_n), .start(b_start), .in_data(b_in),
        .busy(b_busy), .done(b_done), .int_ovf(b_ovf), .dig_valid(b_valid),
        .dig_ready(dig_ready), .dig_data(b_data), .dig_index(b_index), .dig_last(b_last)
    );

    always #5 clk = ~clk;

    int          sel = 0;
    logic        o_busy, o_done, o_ovf, o_valid, o_last;
    logic [3:0]  o_data;
    logic [7:0]  o_index;

    always_comb begin
        if (sel == 1) begin
            o_busy = b_busy; o_done = b_done; o_ovf = b_ovf; o_valid = b_valid;
            o_last = b_last; o_data = b_data; o_index = 8'(b_index);
        end else begin
            o_busy = s_busy; o_done = s_done; o_ovf = s_ovf; o_valid = s_valid;
            o_last = s_last; o_data = s_data; o_index = 8'(s_index);
        end
    end

    int   n_pass = 0;
    int   n_fail = 0;
    int   n_total = 0;
    int   exp_q[$];
    int   obs_q[$];
    logic exp_ovf;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference digits straight from the arithmetic definition, using wide integers.
    function automatic void build_model(input logic [511:0] d, input int fw, input int ndig);
        logic [511:0] mask, frac, p, ip;
        exp_q.delete();
        mask = (512'd1 << fw) - 512'd1;
        ip = d >> fw;
        exp_ovf = (ip > 512'd9);
        exp_q.push_back(exp_ovf ? 15 : int'(ip));
        frac = d & mask;
        for (int k = 1; k <= ndig; k++) begin
            p = frac * 512'd10;
            exp_q.push_back(int'(p >> fw));
            frac = p & mask;
        end
    endfunction

    task automatic capture(input int which, input logic [511:0] d);
        sel = which;
        if (which == 1) begin
            b_in = d; b_start = 1'b1;
        end else begin
            s_in = d[31:0]; s_start = 1'b1;
        end
        @(posedge clk); #1;
        s_start = 1'b0;
        b_start = 1'b0;
    endtask

    // mode 0: ready always high, 1: random ready, 2: five-cycle stall at index 1.
    task automatic stream(input int ndig, input int mode, input bit poke);
        int idx, cyc, stall;
        bit fin;
        idx = 0; cyc = 0; stall = 0; fin = 1'b0;
        obs_q.delete();
        while (!fin && cyc < 10 * ndig + 50) begin
            cyc++;
            if (o_valid) begin
                if (idx > ndig) begin
                    check("extra_digit_valid", o_valid, 0);
                    fin = 1'b1;
                end else begin
                    check("dig_data", o_data, exp_q[idx]);
                    check("dig_index", o_index, idx);
                    check("dig_last", o_last, (idx == ndig));
                    check("int_ovf", o_ovf, exp_ovf);
                    check("busy_valid", o_busy, 1);
                    check("done_valid", o_done, 0);
                    case (mode)
                        0: dig_ready = 1'b1;
                        1: dig_ready = 1'($urandom_range(0, 1));
                        default: begin
                            dig_ready = !(idx == 1 && stall < 5);
                            if (!dig_ready) stall++;
                        end
                    endcase
                    if (dig_ready) begin
                        obs_q.push_back(int'(o_data));
                        idx++;
                    end
                end
            end else if (idx > ndig) begin
                check("done_end", o_done, 1);
                check("busy_end", o_busy, 0);
                if (mode == 0) check("done_latency", cyc, 2 * ndig + 2);
                fin = 1'b1;
            end else begin
                check("busy_calc", o_busy, 1);
                check("done_calc", o_done, 0);
            end
            if (poke) begin
                s_start = (cyc == 2 || cyc == 3);
                s_in    = 32'h0009_1234;
            end
            if (!fin) begin
                @(posedge clk); #1;
            end
        end
        s_start = 1'b0;
        if (!fin) check("stream_timeout", 0, 1);
    endtask

    logic [511:0] e_fix, term, rnd;

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", s_busy, 0);
        check("rst_done", s_done, 0);
        check("rst_valid", s_valid, 0);
        check("rst_data", s_data, 0);
        check("rst_index", s_index, 0);
        check("rst_last", s_last, 0);
        check("rst_ovf", s_ovf, 0);
        check("rst_big_valid", b_valid, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle_busy", s_busy, 0);

        // Basic conversion with exact latency.
        build_model(512'h0002_8000, S_FW, S_N);
        capture(0, 512'h0002_8000);
        stream(S_N, 0, 1'b0);

        // Integer overflow, re-captured straight from DONE.
        build_model(512'h000C_4000, S_FW, S_N);
        capture(0, 512'h000C_4000);
        stream(S_N, 1, 1'b0);

        // Backpressure at index 1.
        build_model(512'h0000_5555, S_FW, S_N);
        capture(0, 512'h0000_5555);
        stream(S_N, 2, 1'b0);

        // Start pulsed in CALC and FRAC_OUT with other data must be ignored.
        build_model(512'h0003_1415, S_FW, S_N);
        capture(0, 512'h0003_1415);
        stream(S_N, 0, 1'b1);

        // Reset in the middle of the stream.
        build_model(512'h0002_8000, S_FW, S_N);
        capture(0, 512'h0002_8000);
        dig_ready = 1'b1;
        for (int i = 0; i < 20 && !(s_valid && s_index == 2); i++) begin
            @(posedge clk); #1;
        end
        check("reach_idx2", s_index, 2);
        rst_n = 1'b0;
        #1;
        check("arst_busy", s_busy, 0);
        check("arst_done", s_done, 0);
        check("arst_valid", s_valid, 0);
        check("arst_data", s_data, 0);
        check("arst_index", s_index, 0);
        check("arst_last", s_last, 0);
        check("arst_ovf", s_ovf, 0);
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_valid", s_valid, 0);
        check("post_rst_busy", s_busy, 0);
        capture(0, 512'h0002_8000);
        stream(S_N, 1, 1'b0);

        // Random fractions and integer parts with random backpressure.
        for (int t = 0; t < 6; t++) begin
            rnd = '0;
            rnd[15:0]  = 16'($urandom);
            rnd[31:16] = (t % 2 == 0) ? 16'($urandom_range(0, 15)) : 16'($urandom);
            build_model(rnd, S_FW, S_N);
            capture(0, rnd);
            stream(S_N, 1, 1'b0);
        end

        // Full width: e from the truncated series sum of 1/k!.
        term  = 512'd1 << B_FW;
        e_fix = '0;
        for (int k = 1; k < 200 && term != 0; k++) begin
            e_fix = e_fix + term;
            term  = term / k;
        end
        build_model(e_fix, B_FW, B_N);
        capture(1, e_fix);
        stream(B_N, 1, 1'b0);
        check("e_digit0", (obs_q.size() > 0) ? obs_q[0] : -1, 2);
        check("e_digit1", (obs_q.size() > 1) ? obs_q[1] : -1, 7);
        check("e_digit2", (obs_q.size() > 2) ? obs_q[2] : -1, 1);
        check("e_digit3", (obs_q.size() > 3) ? obs_q[3] : -1, 8);
        check("e_digit_count", obs_q.size(), B_N + 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

endmodule
